// File: rtl/tlul_socket_m1_rr.sv
// TL-UL M:1 socket: round-robin merge of M hosts onto one device port through a
// one-entry request slot, with host-index source tagging and response routing.
package tluh_32_pkg;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_DBW = 4;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned TL_DIW = 1;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;
endpackage

module tlul_socket_m1_rr #(
    parameter int unsigned M = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  tluh_32_pkg::tl_h2d_t  tl_h_i [M],
    output tluh_32_pkg::tl_d2h_t  tl_h_o [M],
    output tluh_32_pkg::tl_h2d_t  tl_d_o,
    input  tluh_32_pkg::tl_d2h_t  tl_d_i
);
    localparam int unsigned IDW = $clog2(M);
    localparam int unsigned AIW = tluh_32_pkg::TL_AIW;

    logic                 r_slot_valid;
    logic [IDW-1:0]       r_rr_ptr;
    tluh_32_pkg::tl_h2d_t r_slot;

    logic                 w_slot_free;
    logic                 w_any;
    logic                 w_load;
    logic [IDW-1:0]       w_gnt;
    logic [IDW-1:0]       w_sel;
    logic                 w_sel_ok;
    tluh_32_pkg::tl_h2d_t w_req;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int unsigned k);
        return IDW'((32'(base) + k) % M);
    endfunction

    // Round-robin pick starting at r_rr_ptr
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int unsigned k = 0; k < M; k++) begin
            if (!w_any && tl_h_i[rr_idx(r_rr_ptr, k)].a_valid) begin
                w_any = 1'b1;
                w_gnt = rr_idx(r_rr_ptr, k);
            end
        end
    end

    assign w_slot_free = !r_slot_valid || tl_d_i.a_ready;
    assign w_load      = !rst_i && w_slot_free && w_any;

    always_comb begin
        w_req          = tl_h_i[w_gnt];
        w_req.a_source = {tl_h_i[w_gnt].a_source[AIW-1-IDW:0], w_gnt};
    end

    // Request slot and arbitration pointer; payload needs no reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_slot_valid <= 1'b0;
            r_rr_ptr     <= '0;
        end else if (w_load) begin
            r_slot_valid <= 1'b1;
            r_slot       <= w_req;
            r_rr_ptr     <= rr_idx(w_gnt, 1);
        end else if (tl_d_i.a_ready) begin
            r_slot_valid <= 1'b0;
        end
    end

    assign w_sel    = tl_d_i.d_source[IDW-1:0];
    assign w_sel_ok = (32'(w_sel) < M);

    // Response steering by source tag; untagged-range responses are sunk
    always_comb begin
        tl_d_o         = r_slot;
        tl_d_o.a_valid = r_slot_valid;
        tl_d_o.d_ready = 1'b1;
        for (int unsigned i = 0; i < M; i++) begin
            tl_h_o[i]          = tl_d_i;
            tl_h_o[i].d_source = tl_d_i.d_source >> IDW;
            tl_h_o[i].d_valid  = 1'b0;
            tl_h_o[i].a_ready  = !rst_i && w_slot_free && w_any && (w_gnt == IDW'(i));
            if (w_sel_ok && (w_sel == IDW'(i))) begin
                tl_h_o[i].d_valid = tl_d_i.d_valid && !rst_i;
                tl_d_o.d_ready    = tl_h_i[i].d_ready;
            end
        end
    end
endmodule

// File: tb/tb_tlul_socket_m1_rr.sv
// Scoreboard bench for tlul_socket_m1_rr (M=3): arbitration order, slot
// backpressure, source tagging, response routing and reset behaviour.
module tb_tlul_socket_m1_rr;
    import tluh_32_pkg::*;

    localparam int unsigned M = 3;

    typedef struct {
        logic [7:0]  src;
        logic [31:0] addr;
    } req_t;

    typedef struct {
        int          host;
        logic [7:0]  src;
        logic [31:0] data;
    } rsp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    tl_h2d_t tl_h_i [M];
    tl_d2h_t tl_h_o [M];
    tl_h2d_t tl_d_o;
    tl_d2h_t tl_d_i;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_rr     = 0;

    tlul_socket_m1_rr #(.M(M)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .tl_h_i (tl_h_i),
        .tl_h_o (tl_h_o),
        .tl_d_o (tl_d_o),
        .tl_d_i (tl_d_i)
    );

    always #5 clk = ~clk;

    // Hosts must keep the index field of a_source clear
    always @(negedge clk) begin
        for (int i = 0; i < int'(M); i++) begin
            if (tl_h_i[i].a_valid)
                assert (tl_h_i[i].a_source[7:6] == 2'b00)
                else $error("host %0d drives nonzero index bits in a_source", i);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [M-1:0] a_ready_vec();
        logic [M-1:0] v;
        for (int i = 0; i < int'(M); i++) v[i] = tl_h_o[i].a_ready;
        return v;
    endfunction

    function automatic logic [M-1:0] d_valid_vec();
        logic [M-1:0] v;
        for (int i = 0; i < int'(M); i++) v[i] = tl_h_o[i].d_valid;
        return v;
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < int'(M); i++) begin
            tl_h_i[i]          = '0;
            tl_h_i[i].a_opcode = 3'd4;
            tl_h_i[i].a_mask   = 4'hF;
            tl_h_i[i].d_ready  = 1'b1;
        end
        tl_d_i         = '0;
        tl_d_i.a_ready = 1'b1;
    endtask

    task automatic set_host(input int i, input logic v, input logic [7:0] src, input logic [31:0] addr);
        tl_h_i[i].a_valid   = v;
        tl_h_i[i].a_source  = src;
        tl_h_i[i].a_address = addr;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        req_q.delete();
        rsp_q.delete();
        m_rr = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        for (int i = 0; i < int'(M); i++) set_host(i, 1'b1, 8'h0A + 8'(i), 32'h1000_0000 + 32'(i * 4));
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (tl_d_o.a_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_a_valid cycle %0d: got %b expected 0", c, tl_d_o.a_valid);
            end
            n_checks++;
            if (a_ready_vec() !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_a_ready cycle %0d: got %b expected 000", c, a_ready_vec());
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_ready_vec() !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected 001", a_ready_vec());
        end
        idle_inputs();
    endtask

    task automatic test_fairness();
        req_t e;
        int   g;
        apply_reset();
        for (int i = 0; i < int'(M); i++) set_host(i, 1'b1, 8'h0A + 8'(i), 32'h1000_0000 + 32'(i * 4));
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            if (c > 0) begin
                n_checks++;
                if (tl_d_o.a_valid !== 1'b1 || req_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL fair_dev_valid cycle %0d: got a_valid=%b expected 1", c, tl_d_o.a_valid);
                end else begin
                    e = req_q.pop_front();
                    if (tl_d_o.a_source !== e.src || tl_d_o.a_address !== e.addr) begin
                        n_fail++;
                        $display("FAIL fair_dev_req cycle %0d: got src=%h addr=%h expected src=%h addr=%h",
                                 c, tl_d_o.a_source, tl_d_o.a_address, e.src, e.addr);
                    end
                end
            end
            if (c < 6) begin
                g = -1;
                for (int k = 0; k < int'(M); k++)
                    if (g < 0 && tl_h_i[(m_rr + k) % int'(M)].a_valid) g = (m_rr + k) % int'(M);
                n_checks++;
                if (a_ready_vec() !== 3'(1 << g)) begin
                    n_fail++;
                    $display("FAIL fair_grant cycle %0d: got %b expected %b", c, a_ready_vec(), 3'(1 << g));
                end
                e.src  = (tl_h_i[g].a_source << 2) | 8'(g);
                e.addr = tl_h_i[g].a_address;
                req_q.push_back(e);
                m_rr = (g + 1) % int'(M);
            end else begin
                idle_inputs();
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure();
        req_t e;
        apply_reset();
        tl_d_i.a_ready = 1'b0;
        set_host(1, 1'b1, 8'h05, 32'hA000_0010);
        @(negedge clk);
        n_checks++;
        if (a_ready_vec() !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_first_grant: got %b expected 010", a_ready_vec());
        end
        req_q.push_back('{src: 8'h15, addr: 32'hA000_0010});
        @(posedge clk);
        #1 set_host(1, 1'b1, 8'h07, 32'hA000_0020);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (tl_d_o.a_valid !== 1'b1 || tl_d_o.a_source !== req_q[0].src || tl_d_o.a_address !== req_q[0].addr) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got v=%b src=%h addr=%h expected v=1 src=%h addr=%h",
                         c, tl_d_o.a_valid, tl_d_o.a_source, tl_d_o.a_address, req_q[0].src, req_q[0].addr);
            end
            n_checks++;
            if (a_ready_vec() !== 3'b000) begin
                n_fail++;
                $display("FAIL bp_no_ready cycle %0d: got %b expected 000", c, a_ready_vec());
            end
            @(posedge clk);
            #1;
        end
        tl_d_i.a_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        e = req_q.pop_front();
        if (tl_d_o.a_valid !== 1'b1 || tl_d_o.a_source !== e.src || tl_d_o.a_address !== e.addr) begin
            n_fail++;
            $display("FAIL bp_drain: got v=%b src=%h expected v=1 src=%h", tl_d_o.a_valid, tl_d_o.a_source, e.src);
        end
        n_checks++;
        if (a_ready_vec() !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_reload_grant: got %b expected 010", a_ready_vec());
        end
        req_q.push_back('{src: 8'h1D, addr: 32'hA000_0020});
        @(posedge clk);
        #1 set_host(1, 1'b0, 8'h00, 32'h0);
        @(negedge clk);
        n_checks++;
        if (req_q.size() == 0) begin
            n_fail++;
            $display("FAIL bp_reload: got empty scoreboard expected one entry");
        end else begin
            e = req_q.pop_front();
            if (tl_d_o.a_valid !== 1'b1 || tl_d_o.a_source !== e.src || tl_d_o.a_address !== e.addr) begin
                n_fail++;
                $display("FAIL bp_reload: got v=%b src=%h addr=%h expected v=1 src=%h addr=%h",
                         tl_d_o.a_valid, tl_d_o.a_source, tl_d_o.a_address, e.src, e.addr);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (tl_d_o.a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: got a_valid=%b expected 0", tl_d_o.a_valid);
        end
    endtask

    task automatic test_response_routing();
        rsp_t e;
        idle_inputs();
        tl_h_i[2].d_ready = 1'b0;
        tl_d_i.d_valid    = 1'b1;
        tl_d_i.d_source   = 8'h16;
        tl_d_i.d_data     = 32'hD0D0_0002;
        rsp_q.push_back('{host: 2, src: 8'h05, data: 32'hD0D0_0002});
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (d_valid_vec() !== 3'b100 || tl_h_o[2].d_source !== rsp_q[0].src) begin
                n_fail++;
                $display("FAIL rsp_stall_route cycle %0d: got dv=%b src=%h expected dv=100 src=%h",
                         c, d_valid_vec(), tl_h_o[2].d_source, rsp_q[0].src);
            end
            n_checks++;
            if (tl_d_o.d_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rsp_stall_ready cycle %0d: got %b expected 0", c, tl_d_o.d_ready);
            end
            @(posedge clk);
            #1;
        end
        tl_h_i[2].d_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_accept %0d: got empty scoreboard expected one entry", r);
            end else begin
                e = rsp_q.pop_front();
                if (tl_d_o.d_ready !== 1'b1 || d_valid_vec() !== 3'(1 << e.host) ||
                    tl_h_o[e.host].d_source !== e.src || tl_h_o[e.host].d_data !== e.data) begin
                    n_fail++;
                    $display("FAIL rsp_accept %0d: got rdy=%b dv=%b src=%h data=%h expected rdy=1 dv=%b src=%h data=%h",
                             r, tl_d_o.d_ready, d_valid_vec(), tl_h_o[e.host].d_source, tl_h_o[e.host].d_data,
                             3'(1 << e.host), e.src, e.data);
                end
            end
            @(posedge clk);
            #1;
            if (r == 0) begin
                tl_h_i[2].d_ready = 1'b0;
                tl_d_i.d_source   = 8'h14;
                tl_d_i.d_data     = 32'hD0D0_0000;
                rsp_q.push_back('{host: 0, src: 8'h05, data: 32'hD0D0_0000});
            end
        end
        idle_inputs();
    endtask

    task automatic test_invalid_tag();
        logic [7:0] bad [2];
        bad = '{8'h03, 8'h7F};
        idle_inputs();
        for (int i = 0; i < int'(M); i++) tl_h_i[i].d_ready = 1'b0;
        tl_d_i.d_valid = 1'b1;
        for (int b = 0; b < 2; b++) begin
            tl_d_i.d_source = bad[b];
            @(negedge clk);
            n_checks++;
            if (tl_d_o.d_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL inv_ready src=%h: got %b expected 1", bad[b], tl_d_o.d_ready);
            end
            n_checks++;
            if (d_valid_vec() !== 3'b000) begin
                n_fail++;
                $display("FAIL inv_dvalid src=%h: got %b expected 000", bad[b], d_valid_vec());
            end
            @(posedge clk);
            #1;
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        req_t e;
        apply_reset();
        tl_d_i.a_ready = 1'b0;
        set_host(0, 1'b1, 8'h01, 32'hB000_0000);
        @(negedge clk);
        n_checks++;
        if (a_ready_vec() !== 3'b001) begin
            n_fail++;
            $display("FAIL mr_load_grant: got %b expected 001", a_ready_vec());
        end
        @(posedge clk);
        #1;
        set_host(0, 1'b0, 8'h01, 32'hB000_0000);
        tl_h_i[0].d_ready = 1'b0;
        tl_d_i.d_valid    = 1'b1;
        tl_d_i.d_source   = 8'h14;
        @(negedge clk);
        n_checks++;
        if (tl_d_o.a_valid !== 1'b1 || tl_h_o[0].d_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mr_pending: got a_valid=%b d_valid0=%b expected 1 1", tl_d_o.a_valid, tl_h_o[0].d_valid);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (d_valid_vec() !== 3'b000 || a_ready_vec() !== 3'b000) begin
            n_fail++;
            $display("FAIL mr_in_reset: got dv=%b ar=%b expected 000 000", d_valid_vec(), a_ready_vec());
        end
        for (int i = 0; i < int'(M); i++) set_host(i, 1'b1, 8'h01 + 8'(i), 32'hB000_0000 + 32'(i * 4));
        @(posedge clk);
        #1 rst = 1'b0;
        tl_d_i.d_valid    = 1'b0;
        tl_d_i.a_ready    = 1'b1;
        tl_h_i[0].d_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tl_d_o.a_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mr_slot_dropped: got a_valid=%b expected 0", tl_d_o.a_valid);
        end
        n_checks++;
        if (a_ready_vec() !== 3'b001) begin
            n_fail++;
            $display("FAIL mr_ptr_cleared: got %b expected 001", a_ready_vec());
        end
        req_q.push_back('{src: 8'h04, addr: 32'hB000_0000});
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        e = req_q.pop_front();
        if (tl_d_o.a_valid !== 1'b1 || tl_d_o.a_source !== e.src || tl_d_o.a_address !== e.addr) begin
            n_fail++;
            $display("FAIL mr_resume_req: got v=%b src=%h addr=%h expected v=1 src=%h addr=%h",
                     tl_d_o.a_valid, tl_d_o.a_source, tl_d_o.a_address, e.src, e.addr);
        end
        n_checks++;
        if (a_ready_vec() !== 3'b010) begin
            n_fail++;
            $display("FAIL mr_resume_grant: got %b expected 010", a_ready_vec());
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fairness();
        test_backpressure();
        test_response_routing();
        test_invalid_tag();
        test_mid_reset();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
